// File: rtl/jtagkey_ctrl_pkg.sv
// jtagkey_ctrl shared types: FSM states, driver bundle, sync depth.
// No ports; imported by the sync/debounce cell and the controller.
package jtagkey_ctrl_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  typedef struct packed {
    logic jtag_oe;
    logic nsrst_oe;
    logic nsrst_out;
    logic ntrst_oe;
    logic ntrst_out;
  } drv_t;

  localparam drv_t DRV_OFF = '{default: 1'b1};

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/jtagkey_ctrl_if.sv
// Host pins in, buffer controls out, for the JTAG key controller.
// master: host/board side drives HOST_*, TARGET_PRESENT, nSRST_SENSE.
interface jtagkey_ctrl_if;

  logic HOST_JTAG_OE;
  logic HOST_nSRST_OE;
  logic HOST_nSRST_OUT;
  logic HOST_nTRST_OE;
  logic HOST_nTRST_OUT;
  logic TARGET_PRESENT;
  logic nSRST_SENSE;

  logic JTAG_OE;
  logic nSRST_OE;
  logic nSRST_OUT;
  logic nTRST_OE;
  logic nTRST_OUT;
  logic PRESENT;
  logic EXT_SRST;

  modport master (
    output HOST_JTAG_OE, HOST_nSRST_OE, HOST_nSRST_OUT,
    output HOST_nTRST_OE, HOST_nTRST_OUT,
    output TARGET_PRESENT, nSRST_SENSE,
    input  JTAG_OE, nSRST_OE, nSRST_OUT,
    input  nTRST_OE, nTRST_OUT, PRESENT, EXT_SRST
  );

  modport slave (
    input  HOST_JTAG_OE, HOST_nSRST_OE, HOST_nSRST_OUT,
    input  HOST_nTRST_OE, HOST_nTRST_OUT,
    input  TARGET_PRESENT, nSRST_SENSE,
    output JTAG_OE, nSRST_OE, nSRST_OUT,
    output nTRST_OE, nTRST_OUT, PRESENT, EXT_SRST
  );

endinterface

// File: rtl/jtagkey_sync_debounce.sv
// 2-flop synchronizer with optional stable-level debouncer.
// Ports: clk, rst_n (sync, low), d (async in), q (synced/debounced).
module jtagkey_sync_debounce
  import jtagkey_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter bit BYPASS          = 1'b0,
  parameter bit RST_VAL         = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sff;
  logic                   sd;

  always_ff @(posedge clk) begin
    if (!rst_n) sff <= {SYNC_STAGES{RST_VAL}};
    else        sff <= {sff[SYNC_STAGES-2:0], d};
  end

  assign sd = sff[SYNC_STAGES-1];

  generate
    if (BYPASS) begin : g_byp
      assign q = sd;
    end else begin : g_db
      localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt;
      logic          lvl;

      // Counts cycles the synced input has differed from the
      // committed level; any return to the level restarts it.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt <= '0;
          lvl <= RST_VAL;
        end else if (sd == lvl) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          cnt <= '0;
          lvl <= sd;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      assign q = lvl;
    end
  endgenerate

endmodule

// File: rtl/jtagkey_ctrl.sv
// JTAG buffer enable/reset controller: presence gating, nSRST pulse
// stretch + settle mask, target reset detect. Ports: CLK, nRST, bus.
module jtagkey_ctrl
  import jtagkey_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = 1024,
  parameter int SRST_MIN_CYCLES    = 256,
  parameter int SRST_SETTLE_CYCLES = 64
) (
  input logic           CLK,
  input logic           nRST,
  jtagkey_ctrl_if.slave bus
);

  localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, SRST_MIN_CYCLES,
                                  SRST_SETTLE_CYCLES)) + 1;
  localparam logic [CW-1:0] HOLD_LD = CW'(SRST_MIN_CYCLES - 1);
  localparam logic [CW-1:0] SETL_LD = CW'(SRST_SETTLE_CYCLES - 1);

  logic s_jtag, s_soe, s_sout, s_toe, s_tout, s_sense;
  logic present, sense_q, srst_req;

  jtagkey_sync_debounce #(.BYPASS(1'b1), .RST_VAL(1'b1)) u_s_jtag (
    .clk(CLK), .rst_n(nRST), .d(bus.HOST_JTAG_OE), .q(s_jtag)
  );
  jtagkey_sync_debounce #(.BYPASS(1'b1), .RST_VAL(1'b1)) u_s_soe (
    .clk(CLK), .rst_n(nRST), .d(bus.HOST_nSRST_OE), .q(s_soe)
  );
  jtagkey_sync_debounce #(.BYPASS(1'b1), .RST_VAL(1'b1)) u_s_sout (
    .clk(CLK), .rst_n(nRST), .d(bus.HOST_nSRST_OUT), .q(s_sout)
  );
  jtagkey_sync_debounce #(.BYPASS(1'b1), .RST_VAL(1'b1)) u_s_toe (
    .clk(CLK), .rst_n(nRST), .d(bus.HOST_nTRST_OE), .q(s_toe)
  );
  jtagkey_sync_debounce #(.BYPASS(1'b1), .RST_VAL(1'b1)) u_s_tout (
    .clk(CLK), .rst_n(nRST), .d(bus.HOST_nTRST_OUT), .q(s_tout)
  );
  jtagkey_sync_debounce #(.BYPASS(1'b1), .RST_VAL(1'b1)) u_s_sense (
    .clk(CLK), .rst_n(nRST), .d(bus.nSRST_SENSE), .q(s_sense)
  );
  jtagkey_sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .BYPASS(1'b0),
    .RST_VAL(1'b0)
  ) u_present (
    .clk(CLK), .rst_n(nRST), .d(bus.TARGET_PRESENT), .q(present)
  );

  // Only a drive-low request counts; nSRST is never driven high.
  assign srst_req = !s_soe && !s_sout;

  state_t        st, st_nx;
  logic [CW-1:0] cnt, cnt_nx;
  drv_t          drv_q, drv_nx;
  logic          ext_q, ext_nx;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      st      <= ST_IDLE;
      cnt     <= '0;
      drv_q   <= DRV_OFF;
      ext_q   <= 1'b0;
      sense_q <= 1'b1;
    end else begin
      st      <= st_nx;
      cnt     <= cnt_nx;
      drv_q   <= drv_nx;
      ext_q   <= ext_nx;
      sense_q <= s_sense;
    end
  end

  always_comb begin
    st_nx  = st;
    cnt_nx = cnt;
    drv_nx = DRV_OFF;
    ext_nx = 1'b0;

    unique case (st)
      ST_IDLE: begin
        if (present) st_nx = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (srst_req) begin
          st_nx  = ST_HOLD;
          cnt_nx = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CW'(1);
        end else if (!srst_req) begin
          st_nx  = ST_SETTLE;
          cnt_nx = SETL_LD;
        end
      end
      ST_SETTLE: begin
        if (srst_req) begin
          st_nx  = ST_HOLD;
          cnt_nx = HOLD_LD;
        end else if (cnt == '0) begin
          st_nx = ST_ACTIVE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: st_nx = ST_IDLE;
    endcase

    if (!present && st != ST_IDLE) begin
      st_nx  = ST_IDLE;
      cnt_nx = '0;
    end

    // Decode from the next state so host pins reach the pads in
    // two sync stages plus this one register.
    if (st_nx != ST_IDLE) begin
      drv_nx.jtag_oe   = s_jtag;
      drv_nx.ntrst_oe  = s_toe;
      drv_nx.ntrst_out = s_tout;
    end
    if (st_nx == ST_HOLD) begin
      drv_nx.nsrst_oe  = 1'b0;
      drv_nx.nsrst_out = 1'b0;
    end

    ext_nx = (st == ST_ACTIVE) && sense_q && !s_sense;
  end

  assign bus.JTAG_OE   = drv_q.jtag_oe;
  assign bus.nSRST_OE  = drv_q.nsrst_oe;
  assign bus.nSRST_OUT = drv_q.nsrst_out;
  assign bus.nTRST_OE  = drv_q.ntrst_oe;
  assign bus.nTRST_OUT = drv_q.ntrst_out;
  assign bus.PRESENT   = present;
  assign bus.EXT_SRST  = ext_q;

endmodule

// File: tb/tb_jtagkey_ctrl.sv
// Scoreboard bench for jtagkey_ctrl: stimulus schedules expected output
// edges (cycle, value); a monitor matches every observed output edge.
module tb_jtagkey_ctrl;

  localparam int DB  = 1024;
  localparam int MIN = 256;
  localparam int SET = 64;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  jtagkey_ctrl_if bus();

  jtagkey_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .SRST_MIN_CYCLES(MIN),
    .SRST_SETTLE_CYCLES(SET)
  ) dut (
    .CLK(clk),
    .nRST(nrst),
    .bus(bus)
  );

  typedef struct {
    int   sig;
    int   cyc;
    logic val;
  } ev_t;

  ev_t        q[$];
  int         cyc;
  int         n_run  = 0;
  int         n_fail = 0;
  logic       mon_en = 1'b0;
  logic [6:0] prev;
  logic       last[7];
  logic [6:0] rst_v = 7'b0011111;
  string      nm[7] = '{"JTAG_OE", "nSRST_OE", "nSRST_OUT", "nTRST_OE",
                        "nTRST_OUT", "PRESENT", "EXT_SRST"};

  // bit s of this vector is output s in nm[]
  function automatic logic [6:0] outs();
    return {bus.EXT_SRST, bus.PRESENT, bus.nTRST_OUT, bus.nTRST_OE,
            bus.nSRST_OUT, bus.nSRST_OE, bus.JTAG_OE};
  endfunction

  function automatic void sched(int s, int c, logic v);
    if (v !== last[s]) begin
      q.push_back('{sig: s, cyc: c, val: v});
      last[s] = v;
    end
  endfunction

  always @(posedge clk) begin
    if (!nrst) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    logic [6:0] v;
    int         idx;
    if (mon_en) begin
      v = outs();
      for (int s = 0; s < 7; s++) begin
        if (v[s] !== prev[s]) begin
          idx = -1;
          for (int i = 0; i < q.size(); i++)
            if (idx < 0 && q[i].sig == s) idx = i;
          n_run++;
          if (idx < 0) begin
            n_fail++;
            $display("FAIL %s unexpected edge: got %b at cyc %0d, want no change",
                     nm[s], v[s], cyc);
          end else begin
            if (q[idx].cyc != cyc || q[idx].val !== v[s]) begin
              n_fail++;
              $display("FAIL %s edge: got %b at cyc %0d, want %b at cyc %0d",
                       nm[s], v[s], cyc, q[idx].val, q[idx].cyc);
            end
            q.delete(idx);
          end
        end
      end
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc < cyc) begin
          n_run++;
          n_fail++;
          $display("FAIL %s missed edge: got none by cyc %0d, want %b at cyc %0d",
                   nm[q[i].sig], cyc, q[i].val, q[i].cyc);
          q.delete(i);
        end
      end
      prev = v;
    end
  end

  task automatic wait_cyc(int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic req(logic on);
    bus.HOST_nSRST_OE  = !on;
    bus.HOST_nSRST_OUT = !on;
  endtask

  initial begin
    int n, r, m, t, k;
    int lens[4];
    int ks[3];
    int gl[3];

    bus.HOST_JTAG_OE   = 1'b0;
    bus.HOST_nSRST_OE  = 1'b1;
    bus.HOST_nSRST_OUT = 1'b1;
    bus.HOST_nTRST_OE  = 1'b1;
    bus.HOST_nTRST_OUT = 1'b1;
    bus.TARGET_PRESENT = 1'b1;
    bus.nSRST_SENSE    = 1'b1;
    for (int s = 0; s < 7; s++) last[s] = rst_v[s];

    repeat (3) @(negedge clk);
    n_run++;
    if (outs() !== rst_v) begin
      n_fail++;
      $display("FAIL reset outputs: got %b, want %b", outs(), rst_v);
    end

    // power-up with target present: PRESENT after sync+debounce, then ACTIVE
    prev   = outs();
    mon_en = 1'b1;
    nrst   = 1'b1;
    sched(5, DB + 2, 1'b1);
    sched(0, DB + 3, 1'b0);
    wait_cyc(DB + 10);

    // random JTAG/nTRST host patterns pass through with 3-cycle latency
    for (int i = 0; i < 8; i++) begin
      wait_cyc($urandom_range(1, 12));
      bus.HOST_JTAG_OE   = 1'($urandom_range(0, 1));
      bus.HOST_nTRST_OE  = 1'($urandom_range(0, 1));
      bus.HOST_nTRST_OUT = 1'($urandom_range(0, 1));
      sched(0, cyc + 3, bus.HOST_JTAG_OE);
      sched(3, cyc + 3, bus.HOST_nTRST_OE);
      sched(4, cyc + 3, bus.HOST_nTRST_OUT);
    end
    wait_cyc(10);

    // host nSRST request of length L: low drive lasts max(MIN, L) from +3
    lens[0] = 1;
    lens[1] = int'($urandom_range(2, MIN - 1));
    lens[2] = int'($urandom_range(MIN, 400));
    lens[3] = 1000;
    for (int i = 0; i < 4; i++) begin
      n = cyc;
      req(1'b1);
      sched(1, n + 3, 1'b0);
      sched(2, n + 3, 1'b0);
      wait_cyc(lens[i]);
      req(1'b0);
      r = n + 3 + ((lens[i] > MIN) ? lens[i] : MIN);
      sched(1, r, 1'b1);
      sched(2, r, 1'b1);
      wait_cyc(r + 8 - cyc);
      if (i == 0) begin
        // target reset during settle must not pulse EXT_SRST
        bus.nSRST_SENSE = 1'b0;
        wait_cyc(12);
        bus.nSRST_SENSE = 1'b1;
      end
      wait_cyc(SET + 10);
    end

    // re-request k cycles into settle: fresh full hold from that point
    ks[0] = 10;
    ks[1] = SET;
    ks[2] = int'($urandom_range(1, SET - 1));
    for (int i = 0; i < 3; i++) begin
      k = ks[i];
      n = cyc;
      req(1'b1);
      sched(1, n + 3, 1'b0);
      sched(2, n + 3, 1'b0);
      wait_cyc(1);
      req(1'b0);
      r = n + 3 + MIN;
      sched(1, r, 1'b1);
      sched(2, r, 1'b1);
      wait_cyc(r + k - 3 - cyc);
      n = cyc;
      req(1'b1);
      sched(1, n + 3, 1'b0);
      sched(2, n + 3, 1'b0);
      wait_cyc(1);
      req(1'b0);
      sched(1, n + 3 + MIN, 1'b1);
      sched(2, n + 3 + MIN, 1'b1);
      wait_cyc(MIN + SET + 10);
    end

    // target reset seen in ACTIVE: one pulse 3 cycles after the fall
    for (int i = 0; i < 3; i++) begin
      n = cyc;
      bus.nSRST_SENSE = 1'b0;
      sched(6, n + 3, 1'b1);
      sched(6, n + 4, 1'b0);
      wait_cyc($urandom_range(5, 20));
      bus.nSRST_SENSE = 1'b1;
      wait_cyc(6);
    end

    // presence glitches shorter than the debounce window are absorbed
    gl[0] = 500;
    gl[1] = DB - 1;
    gl[2] = int'($urandom_range(1, DB - 2));
    for (int i = 0; i < 3; i++) begin
      bus.TARGET_PRESENT = 1'b0;
      wait_cyc(gl[i]);
      bus.TARGET_PRESENT = 1'b1;
      wait_cyc(10);
    end

    // host asking to drive nSRST high is ignored
    bus.HOST_nSRST_OE  = 1'b0;
    bus.HOST_nSRST_OUT = 1'b1;
    wait_cyc(20);
    bus.HOST_nSRST_OE  = 1'b1;
    wait_cyc(10);

    // target lost mid-hold: PRESENT falls, next cycle everything tristates
    n = cyc;
    req(1'b1);
    sched(1, n + 3, 1'b0);
    sched(2, n + 3, 1'b0);
    wait_cyc(100);
    m = cyc;
    bus.TARGET_PRESENT = 1'b0;
    t = m + 2 + DB;
    sched(5, t, 1'b0);
    for (int s = 0; s < 5; s++) sched(s, t + 1, 1'b1);
    wait_cyc(t + 5 - cyc);
    req(1'b0);
    bus.HOST_JTAG_OE   = !bus.HOST_JTAG_OE;
    bus.HOST_nTRST_OE  = 1'($urandom_range(0, 1));
    bus.HOST_nTRST_OUT = 1'($urandom_range(0, 1));
    wait_cyc(10);

    // target returns: PRESENT, then host values reappear one cycle later
    m = cyc;
    bus.TARGET_PRESENT = 1'b1;
    sched(5, m + DB + 2, 1'b1);
    sched(0, m + DB + 3, bus.HOST_JTAG_OE);
    sched(3, m + DB + 3, bus.HOST_nTRST_OE);
    sched(4, m + DB + 3, bus.HOST_nTRST_OUT);
    wait_cyc(DB + 10);

    // reset mid-hold releases nSRST on the next edge
    n = cyc;
    req(1'b1);
    sched(1, n + 3, 1'b0);
    sched(2, n + 3, 1'b0);
    wait_cyc(10);
    n_run++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL pending edges: got %0d outstanding, want 0", q.size());
    end
    mon_en = 1'b0;
    nrst   = 1'b0;
    @(negedge clk);
    n_run++;
    if (outs() !== rst_v) begin
      n_fail++;
      $display("FAIL reset mid-hold: got %b, want %b", outs(), rst_v);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
